// File: rtl/fpu_pkg.sv
// Shared sizing and payload types for the FPU request scheduler slice.
package fpu_pkg;
    localparam int unsigned DP_LATENCY = 2;
    localparam int unsigned NUM_REQ    = 2;
    localparam int unsigned OP_W       = 128;
    localparam int unsigned RES_W      = 32;
    localparam int unsigned ID_W       = 1;

    // Dot-product operand bundle: result = a*b + c*d
    typedef struct packed {
        logic [31:0] d;
        logic [31:0] c;
        logic [31:0] b;
        logic [31:0] a;
    } dot_op_t;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;
endpackage

// File: rtl/fpu_rr_arb.sv
// Two-way round-robin arbiter; on a tie the requester not granted last wins.
module fpu_rr_arb
    import fpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] eligible,
    output logic [NUM_REQ-1:0] grant_c
);
    logic last_q;

    always_comb begin
        grant_c = '0;
        if (eligible[0] && eligible[1]) begin
            grant_c = last_q ? NUM_REQ'(1) : NUM_REQ'(2);
        end else begin
            grant_c = eligible;
        end
    end

    // Reset leaves last_q at 1 so requester 0 wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (|grant_c) begin
            last_q <= grant_c[1];
        end
    end
endmodule

// File: rtl/fpu_req_scheduler.sv
// Shares one fixed-latency dot-product datapath between two requesters,
// tracking in-flight jobs with a tag pipe and holding results until taken.
module fpu_req_scheduler
    import fpu_pkg::*;
#(
    parameter int unsigned LATENCY = DP_LATENCY,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [OP_W-1:0]   req0_op,
    output logic              req0_ready,
    output logic              res0_valid,
    output logic [RES_W-1:0]  res0_data,
    input  logic              res0_ready,
    input  logic              req1_valid,
    input  logic [OP_W-1:0]   req1_op,
    output logic              req1_ready,
    output logic              res1_valid,
    output logic [RES_W-1:0]  res1_data,
    input  logic              res1_ready,
    output logic              dp_valid,
    output logic [OP_W-1:0]   dp_op,
    input  logic [RES_W-1:0]  dp_result,
    output logic              busy,
    output logic [CNT_W-1:0]  jobs_issued
);
    logic [NUM_REQ-1:0] out_q;
    logic [NUM_REQ-1:0] out_d;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] res_valid_q;
    logic [NUM_REQ-1:0] res_ready;
    logic [NUM_REQ-1:0] take;
    logic [RES_W-1:0]   res_data_q [NUM_REQ];
    tag_t               tag_q [LATENCY];
    tag_t               tag_in;
    tag_t               tag_out;

    // A requester with a job outstanding is never eligible, which also blocks
    // re-accept in the cycle its result is consumed
    assign eligible  = {req1_valid & ~out_q[1], req0_valid & ~out_q[0]} & {NUM_REQ{~rst}};
    assign res_ready = {res1_ready, res0_ready};
    assign take      = res_valid_q & res_ready;
    assign out_d     = (out_q & ~take) | grant;

    fpu_rr_arb u_arb (
        .clk      (clk),
        .rst      (rst),
        .eligible (eligible),
        .grant_c  (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign dp_valid   = |grant;

    always_comb begin
        dp_op = '0;
        if (grant[0]) begin
            dp_op = req0_op;
        end else if (grant[1]) begin
            dp_op = req1_op;
        end
    end

    assign tag_in.valid = |grant;
    assign tag_in.id    = ID_W'(grant[1]);
    assign tag_out      = tag_q[LATENCY-1];

    assign res0_valid = res_valid_q[0];
    assign res1_valid = res_valid_q[1];
    assign res0_data  = res_data_q[0];
    assign res1_data  = res_data_q[1];

    // Job tracking, tag pipe, result slots and issue counter
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            busy        <= 1'b0;
            jobs_issued <= '0;
            res_valid_q <= '0;
            for (int i = 0; i < int'(LATENCY); i++) begin
                tag_q[i] <= '0;
            end
            for (int n = 0; n < int'(NUM_REQ); n++) begin
                res_data_q[n] <= '0;
            end
        end else begin
            out_q <= out_d;
            busy  <= |out_d;
            if (dp_valid) begin
                jobs_issued <= jobs_issued + CNT_W'(1);
            end
            tag_q[0] <= tag_in;
            for (int i = 1; i < int'(LATENCY); i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            for (int n = 0; n < int'(NUM_REQ); n++) begin
                if (take[n]) begin
                    res_valid_q[n] <= 1'b0;
                end
                if (tag_out.valid && (tag_out.id == ID_W'(n))) begin
                    res_valid_q[n] <= 1'b1;
                    res_data_q[n]  <= dp_result;
                end
            end
        end
    end
endmodule

// File: tb/tb_fpu_req_scheduler.sv
// Directed bench for fpu_req_scheduler with a behavioural dot-product datapath.
module tb_fpu_req_scheduler;
    import fpu_pkg::*;

    localparam int unsigned CNT_W = 4;
    localparam logic [127:0] OP_A = {32'h40800000, 32'h3F800000, 32'h40400000, 32'h40000000}; // 2*3+1*4
    localparam logic [127:0] OP_B = {32'h3F800000, 32'h3F000000, 32'h40000000, 32'h3FC00000}; // 1.5*2+0.5*1
    localparam logic [127:0] OP_C = {32'h40400000, 32'h40400000, 32'h40000000, 32'hBF800000}; // -1*2+3*3

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid, req1_valid, req0_ready, req1_ready;
    logic              res0_valid, res1_valid, res0_ready, res1_ready;
    logic              dp_valid, busy;
    logic [127:0]      req0_op, req1_op, dp_op;
    logic [31:0]       res0_data, res1_data, dp_result;
    logic [CNT_W-1:0]  jobs_issued;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fpu_req_scheduler #(.LATENCY(DP_LATENCY), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_ready(req0_ready),
        .res0_valid(res0_valid), .res0_data(res0_data), .res0_ready(res0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_ready(req1_ready),
        .res1_valid(res1_valid), .res1_data(res1_data), .res1_ready(res1_ready),
        .dp_valid(dp_valid), .dp_op(dp_op), .dp_result(dp_result),
        .busy(busy), .jobs_issued(jobs_issued)
    );

    function automatic real sp2r(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:0] == 31'd0) return 0.0;
        d = {b[31], 11'(int'(b[30:23]) + 896), b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        return {d[63], 8'(int'(d[62:52]) - 896), d[51:29]};
    endfunction

    function automatic logic [31:0] dot(input logic [127:0] op);
        dot_op_t o;
        o = op;
        return r2sp(sp2r(o.a) * sp2r(o.b) + sp2r(o.c) * sp2r(o.d));
    endfunction

    // Datapath model: result appears exactly DP_LATENCY cycles after issue, junk otherwise
    logic [1:0]  mv = 2'b00;
    logic [31:0] mr [2];
    always @(posedge clk) begin
        mv[0] <= dp_valid;
        mr[0] <= dot(dp_op);
        mv[1] <= mv[0];
        mr[1] <= mr[0];
    end
    assign dp_result = mv[1] ? mr[1] : 32'hDEADBEEF;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got0, got1;
        int          seq [8];
        int          g, cnt;
        logic        seen;

        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = '0; req1_op = '0; res0_ready = 1'b0; res1_ready = 1'b0;
        tick();
        // Reset blocks acceptance
        req0_valid = 1'b1; req0_op = OP_A;
        settle();
        check("rst_ready", 128'(req0_ready), 128'(0));
        check("rst_dpv", 128'(dp_valid), 128'(0));
        tick();
        rst = 1'b0; req0_valid = 1'b0;
        settle();
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_jobs", 128'(jobs_issued), 128'(0));
        check("rst_res0v", 128'(res0_valid), 128'(0));
        check("idle_dpop", dp_op, 128'(0));

        // Single job
        req0_valid = 1'b1; req0_op = OP_A;
        settle();
        check("s_ready", 128'(req0_ready), 128'(1));
        check("s_dpv", 128'(dp_valid), 128'(1));
        check("s_dpop", dp_op, OP_A);
        tick();
        req0_valid = 1'b0;
        check("s_e1_res", 128'(res0_valid), 128'(0));
        check("s_e1_busy", 128'(busy), 128'(1));
        check("s_jobs", 128'(jobs_issued), 128'(1));
        tick();
        check("s_e2_res", 128'(res0_valid), 128'(0));
        tick();
        check("s_e3_res", 128'(res0_valid), 128'(1));
        check("s_data", 128'(res0_data), 128'(32'h41200000));
        res0_ready = 1'b1;
        tick();
        res0_ready = 1'b0;
        check("s_taken", 128'(res0_valid), 128'(0));
        check("s_idle_busy", 128'(busy), 128'(0));

        // Contention right after reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_valid = 1'b1; req0_op = OP_A; req1_valid = 1'b1; req1_op = OP_B;
        res0_ready = 1'b1; res1_ready = 1'b1;
        settle();
        check("c_r0_first", 128'(req0_ready), 128'(1));
        check("c_r1_wait", 128'(req1_ready), 128'(0));
        tick();
        check("c_r0_second", 128'(req0_ready), 128'(0));
        check("c_r1_second", 128'(req1_ready), 128'(1));
        check("c_dpop1", dp_op, OP_B);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        got0 = '0; got1 = '0;
        for (int i = 0; i < 12; i++) begin
            if (res0_valid) got0 = res0_data;
            if (res1_valid) got1 = res1_data;
            tick();
        end
        check("c_res0", 128'(got0), 128'(32'h41200000));
        check("c_res1", 128'(got1), 128'(32'h40600000));
        check("c_jobs", 128'(jobs_issued), 128'(2));

        // Backpressure on requester 0 while requester 1 is served
        res0_ready = 1'b0;
        req0_valid = 1'b1; req0_op = OP_A;
        settle();
        check("b_accept", 128'(req0_ready), 128'(1));
        tick();
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (res0_valid) seen = 1'b1;
            else tick();
        end
        check("b_res_arrives", 128'(seen), 128'(1));
        got1 = '0;
        for (int i = 0; i < 10; i++) begin
            req1_valid = (i == 0); req1_op = OP_C;
            settle();
            if (i == 0) check("b_r1_served", 128'(req1_ready), 128'(1));
            check("b_hold_v", 128'(res0_valid), 128'(1));
            check("b_hold_d", 128'(res0_data), 128'(32'h41200000));
            check("b_no_reaccept", 128'(req0_ready), 128'(0));
            check("b_busy", 128'(busy), 128'(1));
            if (res1_valid) got1 = res1_data;
            tick();
        end
        req1_valid = 1'b0;
        check("b_res1", 128'(got1), 128'(32'h40E00000));
        res0_ready = 1'b1;
        tick();
        req0_valid = 1'b0;
        check("b_released", 128'(res0_valid), 128'(0));
        for (int i = 0; i < 6; i++) tick();

        // Fairness with both requesters saturating
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_valid = 1'b1; req0_op = OP_A; req1_valid = 1'b1; req1_op = OP_B;
        res0_ready = 1'b1; res1_ready = 1'b1;
        g = 0;
        for (int cyc = 0; cyc < 60 && g < 8; cyc++) begin
            settle();
            check("f_onehot", 128'(req0_ready & req1_ready), 128'(0));
            if (req0_ready) begin seq[g] = 0; g++; end
            else if (req1_ready) begin seq[g] = 1; g++; end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("f_count", 128'(g), 128'(8));
        for (int i = 0; i < 8; i++) check($sformatf("f_seq%0d", i), 128'(seq[i]), 128'(i % 2));
        for (int i = 0; i < 6; i++) tick();

        // Reset one cycle after accept discards the job
        req0_valid = 1'b1; req0_op = OP_A;
        settle();
        check("r_accept", 128'(req0_ready), 128'(1));
        tick();
        req0_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (res0_valid) seen = 1'b1;
            tick();
        end
        check("r_no_result", 128'(seen), 128'(0));
        check("r_busy", 128'(busy), 128'(0));
        check("r_jobs", 128'(jobs_issued), 128'(0));

        // Counter wrap: 17 jobs on a 4-bit counter
        cnt = 0;
        for (int cyc = 0; cyc < 200 && cnt < 17; cyc++) begin
            req0_valid = 1'b1; req0_op = OP_B;
            settle();
            if (req0_ready) cnt++;
            tick();
        end
        req0_valid = 1'b0;
        check("w_count", 128'(cnt), 128'(17));
        for (int i = 0; i < 6; i++) tick();
        check("w_jobs", 128'(jobs_issued), 128'(1));
        check("w_busy", 128'(busy), 128'(0));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
